// File: rtl/ram_io.sv
// Load/store front end ahead of the Cache: maps byte/half/word CPU accesses onto
// word-aligned Cache accesses with byte-lane enables, and hosts one LED register.
module ram_io #(
    parameter logic [31:0] LED_ADDRESS = 32'hFFFF_FFFC,
    parameter int          LED_WIDTH   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [31:0]          address,
    input  logic [2:0]           read_type,
    input  logic [1:0]           write_type,
    input  logic [31:0]          data_in,
    output logic [31:0]          data_out,
    output logic                 data_out_ready,
    output logic                 busy,
    output logic                 error,
    output logic [LED_WIDTH-1:0] led,
    output logic [31:0]          cache_address,
    output logic [31:0]          cache_data_in,
    output logic [3:0]           cache_write_enable,
    input  logic [31:0]          cache_data_out,
    input  logic                 cache_data_out_ready,
    input  logic                 cache_busy
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT} state_t;

    state_t      state, next_state;
    logic [1:0]  off_q;
    logic [2:0]  read_type_q;

    logic [1:0]  off;
    logic [1:0]  size;
    logic        is_write, is_read, is_led, misaligned, hit;
    logic        accept_rd, accept_wr;
    logic [3:0]  lane_mask;

    // Pulls the addressed lane down to bit 0 and extends it; read_type[2] selects zero extension.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane_off,
                                            input logic [2:0] rt);
        logic [31:0] lane;
        lane = word >> {lane_off, 3'b000};
        case (rt[1:0])
            2'b01:   extract = rt[2] ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b10:   extract = rt[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: extract = lane;
        endcase
    endfunction

    always_comb begin
        off        = address[1:0];
        is_write   = (write_type != 2'b00);
        is_read    = (read_type[1:0] != 2'b00);
        size       = is_write ? write_type : read_type[1:0];
        misaligned = ((size == 2'b10) && off[0]) || ((size == 2'b11) && (off != 2'b00));
        is_led     = (address == LED_ADDRESS);
        hit        = cache_data_out_ready && !cache_busy;
        accept_wr  = enable && is_write && !misaligned && !is_led;
        accept_rd  = enable && !is_write && is_read && !misaligned && !is_led;
        case (size)
            2'b01:   lane_mask = 4'b0001 << off;
            2'b10:   lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_wr)      next_state = WR_ISSUE;
                else if (accept_rd) next_state = RD_ISSUE;
            end
            RD_ISSUE, RD_WAIT: next_state = hit ? IDLE : RD_WAIT;
            WR_ISSUE:          next_state = WR_WAIT;
            WR_WAIT:           next_state = cache_busy ? WR_WAIT : IDLE;
            default:           next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out           <= '0;
            data_out_ready     <= 1'b0;
            busy               <= 1'b0;
            error              <= 1'b0;
            led                <= '0;
            cache_address      <= '0;
            cache_data_in      <= '0;
            cache_write_enable <= '0;
            off_q              <= '0;
            read_type_q        <= '0;
        end else begin
            busy <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (enable && (is_write || is_read)) begin
                        if (misaligned) begin
                            error <= 1'b1;
                        end else if (is_led) begin
                            // LED traffic is serviced locally; partial writes are dropped.
                            if (is_write) begin
                                if (write_type == 2'b11) led <= data_in[LED_WIDTH-1:0];
                            end else begin
                                data_out       <= {{(32-LED_WIDTH){1'b0}}, led};
                                data_out_ready <= 1'b1;
                            end
                        end else begin
                            cache_address <= {address[31:2], 2'b00};
                            off_q         <= off;
                            read_type_q   <= read_type;
                            if (is_write) begin
                                cache_data_in      <= data_in << {off, 3'b000};
                                cache_write_enable <= lane_mask;
                            end else begin
                                data_out_ready <= 1'b0;
                            end
                        end
                    end
                end
                RD_ISSUE, RD_WAIT: begin
                    if (hit) begin
                        data_out       <= extract(cache_data_out, off_q, read_type_q);
                        data_out_ready <= 1'b1;
                    end
                end
                WR_ISSUE: cache_write_enable <= 4'b0000;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_io.sv
// Directed bench for ram_io with a small word-array Cache model behind it.
module tb_ram_io;

    logic        clk = 1'b0;
    logic        rst, enable;
    logic [31:0] address, data_in, data_out;
    logic [2:0]  read_type;
    logic [1:0]  write_type;
    logic        data_out_ready, busy, error;
    logic [5:0]  led;
    logic [31:0] cache_address, cache_data_in, cache_data_out;
    logic [3:0]  cache_write_enable;
    logic        cache_data_out_ready, cache_busy;

    logic [31:0] mem [0:63];
    int          we_events;
    int          n_cmp, n_fail;

    always #5 clk = ~clk;

    ram_io dut (
        .clk(clk), .rst(rst), .enable(enable), .address(address),
        .read_type(read_type), .write_type(write_type), .data_in(data_in),
        .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy),
        .error(error), .led(led), .cache_address(cache_address),
        .cache_data_in(cache_data_in), .cache_write_enable(cache_write_enable),
        .cache_data_out(cache_data_out), .cache_data_out_ready(cache_data_out_ready),
        .cache_busy(cache_busy)
    );

    assign cache_data_out = mem[cache_address[7:2]];

    always @(posedge clk) begin
        if (cache_write_enable != 4'b0000) begin
            we_events <= we_events + 1;
            for (int i = 0; i < 4; i++)
                if (cache_write_enable[i])
                    mem[cache_address[7:2]][8*i +: 8] <= cache_data_in[8*i +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [2:0] rt, input logic [1:0] wt,
                       input logic [31:0] d);
        address = a; read_type = rt; write_type = wt; data_in = d; enable = 1'b1;
        tick();
        enable = 1'b0; read_type = 3'b000; write_type = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out got %h want 0", data_out); end
        n_cmp++; if (data_out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", data_out_ready); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
        n_cmp++; if (led !== 6'h0) begin n_fail++; $display("FAIL reset_led got %h want 0", led); end
        n_cmp++; if (cache_write_enable !== 4'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", cache_write_enable); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_word();
        req(32'h10, 3'b000, 2'b11, 32'hDEADBEEF);
        n_cmp++; if (cache_write_enable !== 4'b1111) begin n_fail++; $display("FAIL wst_we got %b want 1111", cache_write_enable); end
        n_cmp++; if (cache_address !== 32'h10) begin n_fail++; $display("FAIL wst_addr got %h want 00000010", cache_address); end
        n_cmp++; if (cache_data_in !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wst_data got %h want deadbeef", cache_data_in); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wst_busy1 got %b want 1", busy); end
        tick();
        n_cmp++; if (cache_write_enable !== 4'b0000) begin n_fail++; $display("FAIL wst_we_drop got %b want 0000", cache_write_enable); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wst_busy2 got %b want 1", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wst_busy3 got %b want 0", busy); end
        req(32'h10, 3'b011, 2'b00, 32'h0);
        n_cmp++; if (data_out_ready !== 1'b0) begin n_fail++; $display("FAIL wld_ready1 got %b want 0", data_out_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wld_busy1 got %b want 1", busy); end
        tick();
        n_cmp++; if (data_out_ready !== 1'b1) begin n_fail++; $display("FAIL wld_ready2 got %b want 1", data_out_ready); end
        n_cmp++; if (data_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wld_data got %h want deadbeef", data_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wld_busy2 got %b want 0", busy); end
    endtask

    task automatic test_byte();
        req(32'h13, 3'b000, 2'b01, 32'h00000080);
        n_cmp++; if (cache_write_enable !== 4'b1000) begin n_fail++; $display("FAIL bst_we got %b want 1000", cache_write_enable); end
        n_cmp++; if (cache_data_in !== 32'h80000000) begin n_fail++; $display("FAIL bst_data got %h want 80000000", cache_data_in); end
        n_cmp++; if (cache_address !== 32'h10) begin n_fail++; $display("FAIL bst_addr got %h want 00000010", cache_address); end
        tick(); tick();
        req(32'h13, 3'b001, 2'b00, 32'h0);
        tick();
        n_cmp++; if (data_out !== 32'hFFFFFF80) begin n_fail++; $display("FAIL bld_signed got %h want ffffff80", data_out); end
        req(32'h13, 3'b101, 2'b00, 32'h0);
        tick();
        n_cmp++; if (data_out !== 32'h00000080) begin n_fail++; $display("FAIL bld_unsigned got %h want 00000080", data_out); end
        req(32'h11, 3'b101, 2'b00, 32'h0);
        tick();
        n_cmp++; if (data_out !== 32'h000000BE) begin n_fail++; $display("FAIL bld_lane1 got %h want 000000be", data_out); end
    endtask

    task automatic test_half();
        req(32'h22, 3'b000, 2'b10, 32'h00008001);
        n_cmp++; if (cache_write_enable !== 4'b1100) begin n_fail++; $display("FAIL hst_we got %b want 1100", cache_write_enable); end
        n_cmp++; if (cache_data_in !== 32'h80010000) begin n_fail++; $display("FAIL hst_data got %h want 80010000", cache_data_in); end
        tick(); tick();
        req(32'h22, 3'b010, 2'b00, 32'h0);
        tick();
        n_cmp++; if (data_out !== 32'hFFFF8001) begin n_fail++; $display("FAIL hld_signed got %h want ffff8001", data_out); end
        req(32'h22, 3'b110, 2'b00, 32'h0);
        tick();
        n_cmp++; if (data_out !== 32'h00008001) begin n_fail++; $display("FAIL hld_unsigned got %h want 00008001", data_out); end
    endtask

    task automatic test_misaligned();
        req(32'h21, 3'b010, 2'b00, 32'h0);
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL mis_error got %b want 1", error); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mis_busy got %b want 0", busy); end
        n_cmp++; if (cache_address !== 32'h20) begin n_fail++; $display("FAIL mis_addr got %h want 00000020", cache_address); end
        n_cmp++; if (data_out_ready !== 1'b1) begin n_fail++; $display("FAIL mis_ready got %b want 1", data_out_ready); end
        req(32'h12, 3'b000, 2'b11, 32'h0);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mis_wword_busy got %b want 0", busy); end
        req(32'h10, 3'b011, 2'b00, 32'h0);
        tick();
        n_cmp++; if (data_out !== 32'h80ADBEEF) begin n_fail++; $display("FAIL mis_after_data got %h want 80adbeef", data_out); end
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL mis_sticky got %b want 1", error); end
    endtask

    task automatic test_led();
        int we_before;
        we_before = we_events;
        req(32'hFFFFFFFC, 3'b000, 2'b11, 32'h0000002A);
        n_cmp++; if (led !== 6'h2A) begin n_fail++; $display("FAIL led_write got %h want 2a", led); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL led_busy got %b want 0", busy); end
        req(32'hFFFFFFFC, 3'b000, 2'b01, 32'h00000015);
        n_cmp++; if (led !== 6'h2A) begin n_fail++; $display("FAIL led_byte_ignored got %h want 2a", led); end
        req(32'hFFFFFFFC, 3'b011, 2'b00, 32'h0);
        n_cmp++; if (data_out !== 32'h0000002A) begin n_fail++; $display("FAIL led_read got %h want 0000002a", data_out); end
        n_cmp++; if (data_out_ready !== 1'b1) begin n_fail++; $display("FAIL led_read_ready got %b want 1", data_out_ready); end
        n_cmp++; if (we_events !== we_before) begin n_fail++; $display("FAIL led_no_cache_we got %0d want %0d", we_events, we_before); end
    endtask

    task automatic test_read_wait();
        cache_data_out_ready = 1'b0;
        req(32'h20, 3'b011, 2'b00, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (busy !== 1'b1 || data_out_ready !== 1'b0) begin
                n_fail++; $display("FAIL rdwait_hold busy=%b ready=%b want 1/0", busy, data_out_ready);
            end
        end
        cache_data_out_ready = 1'b1;
        tick();
        n_cmp++; if (data_out !== 32'h80010000 || data_out_ready !== 1'b1) begin
            n_fail++; $display("FAIL rdwait_done data=%h ready=%b want 80010000/1", data_out, data_out_ready);
        end
    endtask

    task automatic test_miss_reset();
        cache_busy = 1'b1;
        req(32'h30, 3'b000, 2'b11, 32'h12345678);
        n_cmp++; if (cache_write_enable !== 4'b1111) begin n_fail++; $display("FAIL miss_we got %b want 1111", cache_write_enable); end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++; if (busy !== 1'b1 || cache_write_enable !== 4'b0000) begin
                n_fail++; $display("FAIL miss_wait busy=%b we=%b want 1/0000", busy, cache_write_enable);
            end
        end
        rst = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0 || cache_write_enable !== 4'b0 || error !== 1'b0 || led !== 6'h0) begin
            n_fail++; $display("FAIL miss_rst_ctl busy=%b we=%b err=%b led=%h want 0", busy, cache_write_enable, error, led);
        end
        n_cmp++; if (data_out !== 32'h0 || data_out_ready !== 1'b0 || cache_address !== 32'h0 || cache_data_in !== 32'h0) begin
            n_fail++; $display("FAIL miss_rst_data dout=%h rdy=%b ca=%h cdi=%h want 0", data_out, data_out_ready, cache_address, cache_data_in);
        end
        rst = 1'b0;
        cache_busy = 1'b0;
        tick();
        req(32'h10, 3'b011, 2'b00, 32'h0);
        tick();
        n_cmp++; if (data_out !== 32'h80ADBEEF || data_out_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_rst_load data=%h ready=%b want 80adbeef/1", data_out, data_out_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        we_events = 0; n_cmp = 0; n_fail = 0;
        rst = 1'b1; enable = 1'b0; address = 32'h0; read_type = 3'b000;
        write_type = 2'b00; data_in = 32'h0;
        cache_data_out_ready = 1'b1; cache_busy = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_led();
        test_read_wait();
        test_miss_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_io.md
Name: ram_io

Overview:
- CPU-facing load/store front end that sits directly upstream of the Cache.
- Turns byte, halfword and word loads/stores at arbitrary byte addresses into 32-bit word accesses with 4-bit byte write enables on the Cache port.
- Performs load extraction with sign/zero extension.
- Decodes one memory-mapped LED register that never reaches the Cache.

Parameters:
- LED_ADDRESS, 32'hFFFF_FFFC: word address of the LED register.
- LED_WIDTH, 6: number of LED output bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  request valid; sampled only when busy=0
- address  in  32  byte address of the request
- read_type  in  3  000 none, 001 byte signed, 010 half signed, 011 word, 101 byte unsigned, 110 half unsigned
- write_type  in  2  00 none, 01 byte, 10 half, 11 word
- data_in  in  32  store data, right-aligned
- data_out  out  32  load result, extended to 32 bits
- data_out_ready  out  1  data_out is valid for the last accepted load
- busy  out  1  request in progress; new requests are ignored
- error  out  1  sticky misaligned-access flag
- led  out  LED_WIDTH  LED register contents
- cache_address  out  32  word-aligned address to the Cache
- cache_data_in  out  32  lane-shifted store data
- cache_write_enable  out  4  byte lane enables; 0 means read
- cache_data_out  in  32  Cache read data
- cache_data_out_ready  in  1  Cache read hit/complete
- cache_busy  in  1  Cache servicing a miss or write-back

Behaviour:
- Reset values:
  - data_out=0, data_out_ready=0, busy=0, error=0, led=0.
  - cache_address=0, cache_data_in=0, cache_write_enable=0.
  - state=IDLE.
- Reset mid-operation aborts the access. cache_write_enable is 0 from the first edge with rst=1.
- Acceptance: in IDLE with enable=1.
  - write_type takes priority over read_type if both are non-zero.
  - Both zero: no-op, stays IDLE.
- Alignment:
  - Half requires address[0]=0. Word requires address[1:0]=00.
  - A misaligned request sets error=1 and returns to IDLE. No Cache access, data_out_ready unchanged.
- LED access (address==LED_ADDRESS):
  - Word write sets led<=data_in[LED_WIDTH-1:0] in 1 cycle, no Cache activity.
  - Any read returns {zeros, led}, zero-extended, with data_out_ready=1 the next cycle.
  - Byte/half writes to the LED address are ignored.
- Lane mapping, with off=address[1:0]:
  - cache_address={address[31:2],2'b00}.
  - cache_data_in=data_in<<(8*off).
  - byte enable=4'b0001<<off; half enable=4'b0011<<off; word enable=4'b1111.
- FSM: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT.
  - IDLE: on a load, register the cache outputs, clear data_out_ready, go RD_ISSUE. On a store, register the cache outputs including enables, go WR_ISSUE.
  - RD_ISSUE/RD_WAIT: hold cache_address. The first cycle with cache_data_out_ready=1 and cache_busy=0 latches the extracted lane into data_out, sets data_out_ready=1, goes IDLE. Otherwise go or stay RD_WAIT.
  - WR_ISSUE: hold the enables for exactly this cycle, go WR_WAIT.
  - WR_WAIT: cache_write_enable=0 while cache_busy=1. The first cycle with cache_busy=0 goes IDLE.
- Extraction:
  - Byte = cache_data_out[8*off+:8]; half = cache_data_out[8*off+:16].
  - Sign- or zero-extended per read_type.
- busy=1 in every state except IDLE. busy is registered, so it is high the cycle after acceptance.
- Hit latency:
  - Load: accept at T, data_out_ready=1 at T+2.
  - Store: accept at T, busy=0 at T+3.
- data_out_ready stays high until the next load is accepted. Stores do not clear it.
- error is cleared only by rst.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> cache sees 4'b1111 at 0x10; data_out=0xDEADBEEF, data_out_ready at accept+2 on a hit.
- Byte store 0x80 @0x13, then signed byte load @0x13 and unsigned byte load @0x13:
  - cache_write_enable=4'b1000, cache_data_in=0x80000000.
  - Signed load gives data_out=0xFFFFFF80; unsigned load gives 0x00000080.
- Half store 0x8001 @0x22, then signed half load @0x22 -> enables=4'b1100, data_out=0xFFFF8001.
- Half load @0x21 -> error=1, busy never asserts, no cache_address change; error remains 1 after later valid accesses until rst.
- Word write 0x2A to LED_ADDRESS, then read it -> led=6'h2A with no cache_write_enable activity; data_out=0x0000002A.
- Store to a miss address with cache_busy held 20 cycles, then rst asserted mid-WR_WAIT -> busy=1 throughout the wait; on reset all outputs return to reset values and state=IDLE.
